// File: rtl/pmem_burst.sv
// pmem_burst: byte-addressed backing store for the cache controller.
// Serves whole lines as critical-word-first bursts that wrap inside the line,
// with a programmable read latency and byte-strobed write beats.
module pmem_burst #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 64,
    parameter int BURST_LEN  = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    output logic                  wr_done,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last
);
    localparam int BYTES   = DATA_W / 8;
    localparam int LINE    = BURST_LEN * BYTES;
    localparam int BYTE_SH = $clog2(BYTES);
    localparam int BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [BEAT_W-1:0] BEAT_MASK = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE - 1);
    // RD_WAIT lasts RD_LATENCY-1 cycles; counter runs 0 .. RD_LATENCY-2
    localparam logic [LAT_W-1:0]  LAT_END   = LAT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

    // Storage is deliberately never reset; the bench preloads it directly.
    logic [7:0] mem [0:(1<<ADDR_W)-1];

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [BEAT_W-1:0]   start_q, start_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                req_ready_q, req_ready_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic                wr_done_q, wr_done_d;

    logic                accept, wr_fire;
    logic [BEAT_W-1:0]   beat_idx;
    logic [ADDR_W-1:0]   beat_addr;

    // req_ready is only registered-high in IDLE, so it doubles as the idle qualifier
    assign accept  = req_valid && req_ready_q;
    assign wr_fire = wr_valid && wr_ready_q;

    // Critical word first: beat k lands on line slot (start + k) mod BURST_LEN
    assign beat_idx  = (start_q + beat_q) & BEAT_MASK;
    assign beat_addr = base_q | (ADDR_W'(beat_idx) << BYTE_SH);

    // Next-state and next-output logic for the burst sequencer
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        start_d   = start_q;
        lat_d     = lat_q;
        base_d    = base_q;
        wr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    base_d  = req_addr & ~LINE_MASK;
                    start_d = BEAT_W'(req_addr >> BYTE_SH) & BEAT_MASK;
                    beat_d  = '0;
                    lat_d   = '0;
                    if (req_we)
                        state_d = WR_BURST;
                    else if (RD_LATENCY == 1)
                        state_d = RD_BURST;
                    else
                        state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_END)
                    state_d = RD_BURST;
                else
                    lat_d = lat_q + LAT_W'(1);
            end
            RD_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            WR_BURST: begin
                if (wr_fire) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d   = IDLE;
                        beat_d    = '0;
                        wr_done_d = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WR_BURST);
        rd_valid_d  = (state_d == RD_BURST);
        rd_last_d   = rd_valid_d && (beat_d == LAST_BEAT);
    end

    // Sequencer state and registered handshake outputs; reset aborts any burst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            start_q     <= '0;
            lat_q       <= '0;
            base_q      <= '0;
            req_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            start_q     <= start_d;
            lat_q       <= lat_d;
            base_q      <= base_d;
            req_ready_q <= req_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Commit the strobed bytes of each accepted write beat
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wr_strb[i])
                    mem[beat_addr + ADDR_W'(i)] <= wr_data[8*i +: 8];
            end
        end
    end

    // Read beats look at memory in the cycle they are presented; bus is zero when idle
    always_comb begin
        rd_data = '0;
        if (rd_valid_q) begin
            for (int i = 0; i < BYTES; i++)
                rd_data[8*i +: 8] = mem[beat_addr + ADDR_W'(i)];
        end
    end

    assign req_ready = req_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_pmem_burst.sv
// tb_pmem_burst: randomized self-checking bench for pmem_burst.
// Instance d0 uses the default geometry (BURST_LEN=4, RD_LATENCY=2);
// instance d1 covers the BURST_LEN=1 / RD_LATENCY=1 corner.
module tb_pmem_burst;
    localparam int AW = 20;
    localparam int DW = 64;
    localparam int NB = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic          wr_valid  [2];
    logic          wr_ready  [2];
    logic [DW-1:0] wr_data   [2];
    logic [NB-1:0] wr_strb   [2];
    logic          wr_done   [2];
    logic          rd_valid  [2];
    logic [DW-1:0] rd_data   [2];
    logic          rd_last   [2];

    int checks = 0;
    int fails  = 0;

    // reference memory image, keyed by (instance << 24) | byte address
    logic [7:0] mm [int];

    // per-cycle observations, index = cycles after the accepting edge
    logic          o_vld [24];
    logic          o_last[24];
    logic          o_rdy [24];
    logic          o_wrdy[24];
    logic          o_done[24];
    logic [DW-1:0] o_data[24];

    // write burst payload and wr_valid pattern
    logic [DW-1:0] wdat [8];
    logic [NB-1:0] wstrb[8];
    bit            wpat [24];

    always #5 clk = ~clk;

    pmem_burst #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4), .RD_LATENCY(2)) d0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]), .wr_strb(wr_strb[0]),
        .wr_done(wr_done[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .rd_last(rd_last[0])
    );

    pmem_burst #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(1), .RD_LATENCY(1)) d1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]), .wr_strb(wr_strb[1]),
        .wr_done(wr_done[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .rd_last(rd_last[1])
    );

    // ---------------- reference model ----------------
    function automatic int rl(int s); return (s != 0) ? 1 : 2; endfunction
    function automatic int bl(int s); return (s != 0) ? 1 : 4; endfunction
    function automatic int key(int s, int a); return (s << 24) | a; endfunction

    // byte address of beat k of a burst requested at a
    function automatic int baddr(int s, logic [AW-1:0] a, int k);
        int ai, line, base, start;
        ai    = int'(a);
        line  = bl(s) * NB;
        base  = ai - (ai % line);
        start = (ai % line) / NB;
        return (base + ((start + k) % bl(s)) * NB) % (1 << AW);
    endfunction

    function automatic logic [DW-1:0] exp_beat(int s, logic [AW-1:0] a, int k);
        logic [DW-1:0] r;
        int b;
        b = baddr(s, a, k);
        for (int i = 0; i < NB; i++) r[8*i +: 8] = mm[key(s, b + i)];
        return r;
    endfunction

    task automatic model_write(int s, logic [AW-1:0] a, int nbeats);
        int b;
        for (int k = 0; k < nbeats; k++) begin
            b = baddr(s, a, k);
            for (int i = 0; i < NB; i++)
                if (wstrb[k][i]) mm[key(s, b + i)] = wdat[k][8*i +: 8];
        end
    endtask

    task automatic poke(int s, int a, logic [7:0] v);
        if (s != 0) d1.mem[a] = v;
        else        d0.mem[a] = v;
        mm[key(s, a)] = v;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // holds the request until the block takes it; leaves us one cycle after the accepting edge
    task automatic wait_accept(int s);
        int n;
        n = 0;
        while (req_ready[s] !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (n >= 40) begin
            fails++;
            $display("FAIL accept_timeout: inst %0d req_ready=%b after %0d cycles, want 1", s, req_ready[s], n);
        end
        tick();
        req_valid[s] = 1'b0;
    endtask

    task automatic run_read(int s, logic [AW-1:0] a);
        req_valid[s] = 1'b1; req_we[s] = 1'b0; req_addr[s] = a;
        wait_accept(s);
        for (int j = 1; j <= rl(s) + bl(s) + 1; j++) begin
            o_vld[j] = rd_valid[s]; o_last[j] = rd_last[s];
            o_rdy[j] = req_ready[s]; o_data[j] = rd_data[s];
            tick();
        end
    endtask

    task automatic run_write(int s, logic [AW-1:0] a, int np);
        int k;
        req_valid[s] = 1'b1; req_we[s] = 1'b1; req_addr[s] = a;
        wait_accept(s);
        k = 0;
        for (int j = 1; j <= np + 2; j++) begin
            o_wrdy[j] = wr_ready[s]; o_done[j] = wr_done[s]; o_rdy[j] = req_ready[s];
            if (j <= np && wpat[j-1]) begin
                wr_valid[s] = 1'b1; wr_data[s] = wdat[k]; wr_strb[s] = wstrb[k]; k++;
            end else if (j <= np) begin
                wr_valid[s] = 1'b0; wr_data[s] = {$urandom, $urandom}; wr_strb[s] = '1;
            end else begin
                // stray beats once the burst is over must not reach memory
                wr_valid[s] = 1'b1; wr_data[s] = {$urandom, $urandom}; wr_strb[s] = '1;
            end
            tick();
        end
        wr_valid[s] = 1'b0;
        model_write(s, a, bl(s));
    endtask

    task automatic fill_payload;
        for (int k = 0; k < 8; k++) begin
            wdat[k]  = {$urandom, $urandom};
            wstrb[k] = NB'($urandom);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b1; req_we[s] = 1'b0; req_addr[s] = AW'('h40);
        end
        repeat (3) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (req_ready[s] !== 1'b0 || rd_valid[s] !== 1'b0 || wr_ready[s] !== 1'b0 ||
                    wr_done[s] !== 1'b0 || rd_last[s] !== 1'b0 || rd_data[s] !== '0) begin
                    fails++;
                    $display("FAIL reset_hold: inst %0d rdy=%b rv=%b wrdy=%b done=%b last=%b data=%h, want all 0",
                             s, req_ready[s], rd_valid[s], wr_ready[s], wr_done[s], rd_last[s], rd_data[s]);
                end
            end
        end
        for (int s = 0; s < 2; s++) req_valid[s] = 1'b0;
        rst = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (req_ready[s] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release: inst %0d req_ready=%b, want 1", s, req_ready[s]);
            end
        end
        repeat (4) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (rd_valid[s] !== 1'b0 || wr_ready[s] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_no_accept: inst %0d rd_valid=%b wr_ready=%b, want 0 0", s, rd_valid[s], wr_ready[s]);
                end
            end
        end
    endtask

    task automatic test_wrapped_read;
        logic [AW-1:0] a;
        int k;
        logic v;
        logic [DW-1:0] ed;
        for (int j = 0; j < 32; j++) poke(0, 'h40 + j, 8'(j));
        a = AW'('h48);
        run_read(0, a);
        for (int j = 1; j <= rl(0) + bl(0) + 1; j++) begin
            k = j - rl(0);
            v = (k >= 0 && k < bl(0));
            ed = v ? exp_beat(0, a, k) : '0;
            checks++;
            if (o_vld[j] !== v || o_last[j] !== (k == bl(0) - 1) || o_rdy[j] !== (j >= rl(0) + bl(0)) || o_data[j] !== ed) begin
                fails++;
                $display("FAIL wrap_read c%0d: vld=%b last=%b rdy=%b data=%h, want %b %b %b %h",
                         j, o_vld[j], o_last[j], o_rdy[j], o_data[j], v, k == bl(0) - 1, j >= rl(0) + bl(0), ed);
            end
        end
        checks++;
        if (o_data[2] !== 64'h0F0E0D0C0B0A0908 || o_data[5] !== 64'h0706050403020100) begin
            fails++;
            $display("FAIL wrap_read_crit: first=%h last=%h, want 0f0e0d0c0b0a0908 0706050403020100", o_data[2], o_data[5]);
        end
    endtask

    task automatic test_strobed_write;
        logic [AW-1:0] a;
        int k;
        logic v;
        logic [DW-1:0] ed;
        for (int j = 0; j < 32; j++) poke(0, 'h100 + j, 8'h00);
        for (int b = 0; b < 4; b++) begin wdat[b] = '1; wstrb[b] = 8'h0F; wpat[b] = 1'b1; end
        a = AW'('h100);
        run_write(0, a, 4);
        for (int j = 1; j <= 6; j++) begin
            checks++;
            if (o_wrdy[j] !== (j <= 4) || o_done[j] !== (j == 5) || o_rdy[j] !== (j > 4)) begin
                fails++;
                $display("FAIL strb_write c%0d: wr_ready=%b wr_done=%b req_ready=%b, want %b %b %b",
                         j, o_wrdy[j], o_done[j], o_rdy[j], j <= 4, j == 5, j > 4);
            end
        end
        run_read(0, a);
        for (int j = 1; j <= rl(0) + bl(0) + 1; j++) begin
            k = j - rl(0);
            v = (k >= 0 && k < bl(0));
            ed = v ? exp_beat(0, a, k) : '0;
            checks++;
            if (o_vld[j] !== v || o_last[j] !== (k == bl(0) - 1) || o_data[j] !== ed) begin
                fails++;
                $display("FAIL strb_readback c%0d: vld=%b last=%b data=%h, want %b %b %h",
                         j, o_vld[j], o_last[j], o_data[j], v, k == bl(0) - 1, ed);
            end
        end
        checks++;
        if (o_data[3] !== 64'h00000000FFFFFFFF) begin
            fails++;
            $display("FAIL strb_value: got %h, want 00000000ffffffff", o_data[3]);
        end
    endtask

    task automatic test_write_gaps;
        logic [AW-1:0] a;
        logic [AW-1:0] nb;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        int k;
        logic [DW-1:0] ed;
        fill_payload();
        for (int j = 0; j < 7; j++) wpat[j] = pat[j];
        a = AW'('h208);
        run_write(0, a, 7);
        for (int j = 1; j <= 9; j++) begin
            checks++;
            if (o_wrdy[j] !== (j <= 7) || o_done[j] !== (j == 8) || o_rdy[j] !== (j > 7)) begin
                fails++;
                $display("FAIL gap_write c%0d: wr_ready=%b wr_done=%b req_ready=%b, want %b %b %b",
                         j, o_wrdy[j], o_done[j], o_rdy[j], j <= 7, j == 8, j > 7);
            end
        end
        // the written line and its neighbour must both match the model exactly
        for (int t = 0; t < 2; t++) begin
            nb = (t == 0) ? a : AW'('h220);
            run_read(0, nb);
            for (int j = rl(0); j < rl(0) + bl(0); j++) begin
                k = j - rl(0);
                ed = exp_beat(0, nb, k);
                checks++;
                if (o_vld[j] !== 1'b1 || o_data[j] !== ed) begin
                    fails++;
                    $display("FAIL gap_readback line%0d beat%0d: vld=%b data=%h, want 1 %h", t, k, o_vld[j], o_data[j], ed);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [AW-1:0] a;
        int k;
        logic v;
        logic [DW-1:0] ed;
        a = AW'($urandom_range(0, 'h7FF));
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = a;
        wait_accept(0);
        repeat (rl(0)) tick();
        checks++;
        if (rd_valid[0] !== 1'b1) begin
            fails++;
            $display("FAIL midread_beat2: rd_valid=%b, want 1", rd_valid[0]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rd_valid[0] !== 1'b0 || rd_last[0] !== 1'b0 || req_ready[0] !== 1'b0 || rd_data[0] !== '0) begin
            fails++;
            $display("FAIL midread_abort: rv=%b last=%b rdy=%b data=%h, want 0 0 0 0", rd_valid[0], rd_last[0], req_ready[0], rd_data[0]);
        end
        repeat (2) begin
            tick();
            checks++;
            if (rd_last[0] !== 1'b0 || rd_valid[0] !== 1'b0) begin
                fails++;
                $display("FAIL midread_hold: rd_valid=%b rd_last=%b, want 0 0", rd_valid[0], rd_last[0]);
            end
        end
        rst = 1'b1;
        tick();
        a = AW'($urandom_range(0, 'h7FF));
        run_read(0, a);
        for (int j = 1; j <= rl(0) + bl(0) + 1; j++) begin
            k = j - rl(0);
            v = (k >= 0 && k < bl(0));
            ed = v ? exp_beat(0, a, k) : '0;
            checks++;
            if (o_vld[j] !== v || o_last[j] !== (k == bl(0) - 1) || o_data[j] !== ed) begin
                fails++;
                $display("FAIL midread_recover c%0d: vld=%b last=%b data=%h, want %b %b %h",
                         j, o_vld[j], o_last[j], o_data[j], v, k == bl(0) - 1, ed);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        fill_payload();
        for (int b = 0; b < 4; b++) wstrb[b] = '1;
        a = AW'($urandom_range(0, 'h7FF));
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = a;
        wait_accept(0);
        for (int b = 0; b < 2; b++) begin
            wr_valid[0] = 1'b1; wr_data[0] = wdat[b]; wr_strb[0] = wstrb[b];
            tick();
        end
        wr_valid[0] = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wr_ready[0] !== 1'b0 || wr_done[0] !== 1'b0) begin
            fails++;
            $display("FAIL midwrite_abort: wr_ready=%b wr_done=%b, want 0 0", wr_ready[0], wr_done[0]);
        end
        tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            checks++;
            if (wr_done[0] !== 1'b0 || wr_ready[0] !== 1'b0) begin
                fails++;
                $display("FAIL midwrite_nodone: wr_done=%b wr_ready=%b, want 0 0", wr_done[0], wr_ready[0]);
            end
        end
        model_write(0, a, 2);
        run_read(0, a);
        for (int k = 0; k < bl(0); k++) begin
            ed = exp_beat(0, a, k);
            checks++;
            if (o_data[rl(0) + k] !== ed) begin
                fails++;
                $display("FAIL midwrite_readback beat%0d: data=%h, want %h", k, o_data[rl(0) + k], ed);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a, b;
        int n, k;
        logic v;
        logic [DW-1:0] ed;
        for (int s = 0; s < 2; s++) begin
            fill_payload();
            a = AW'($urandom_range(0, 'h7FF));
            b = AW'($urandom_range(0, 'h7FF));
            req_valid[s] = 1'b1; req_we[s] = 1'b0; req_addr[s] = a;
            n = 0;
            while (req_ready[s] !== 1'b1 && n < 40) begin tick(); n++; end
            checks++;
            if (n >= 40) begin
                fails++;
                $display("FAIL b2b_timeout: inst %0d req_ready=%b, want 1", s, req_ready[s]);
            end
            tick();
            req_we[s] = 1'b1; req_addr[s] = b;
            for (int j = 1; j <= rl(s) + bl(s); j++) begin
                o_vld[j] = rd_valid[s]; o_last[j] = rd_last[s]; o_rdy[j] = req_ready[s]; o_data[j] = rd_data[s];
                tick();
            end
            for (int j = 1; j <= rl(s) + bl(s); j++) begin
                k = j - rl(s);
                v = (k >= 0 && k < bl(s));
                ed = v ? exp_beat(s, a, k) : '0;
                checks++;
                if (o_vld[j] !== v || o_last[j] !== (k == bl(s) - 1) || o_rdy[j] !== (j == rl(s) + bl(s)) || o_data[j] !== ed) begin
                    fails++;
                    $display("FAIL b2b_read inst%0d c%0d: vld=%b last=%b rdy=%b data=%h, want %b %b %b %h",
                             s, j, o_vld[j], o_last[j], o_rdy[j], o_data[j], v, k == bl(s) - 1, j == rl(s) + bl(s), ed);
                end
            end
            checks++;
            if (wr_ready[s] !== 1'b1 || req_ready[s] !== 1'b0) begin
                fails++;
                $display("FAIL b2b_write_accept: inst %0d wr_ready=%b req_ready=%b, want 1 0", s, wr_ready[s], req_ready[s]);
            end
            req_valid[s] = 1'b0;
            for (int m = 0; m < bl(s); m++) begin
                wr_valid[s] = 1'b1; wr_data[s] = wdat[m]; wr_strb[s] = wstrb[m];
                tick();
            end
            wr_valid[s] = 1'b0;
            checks++;
            if (wr_done[s] !== 1'b1 || req_ready[s] !== 1'b1) begin
                fails++;
                $display("FAIL b2b_write_done: inst %0d wr_done=%b req_ready=%b, want 1 1", s, wr_done[s], req_ready[s]);
            end
            model_write(s, b, bl(s));
            run_read(s, b);
            for (int m = 0; m < bl(s); m++) begin
                ed = exp_beat(s, b, m);
                checks++;
                if (o_data[rl(s) + m] !== ed) begin
                    fails++;
                    $display("FAIL b2b_readback inst%0d beat%0d: data=%h, want %h", s, m, o_data[rl(s) + m], ed);
                end
            end
        end
    endtask

    task automatic test_random;
        int s, np, k;
        logic [AW-1:0] a;
        logic v;
        logic [DW-1:0] ed;
        for (int it = 0; it < 40; it++) begin
            s = $urandom_range(0, 1);
            a = AW'($urandom_range(0, 'h7FF));
            if ($urandom_range(0, 1) == 1) begin
                fill_payload();
                np = 0;
                for (int b = 0; b < bl(s); b++) begin
                    repeat ($urandom_range(0, 2)) begin wpat[np] = 1'b0; np++; end
                    wpat[np] = 1'b1; np++;
                end
                run_write(s, a, np);
                for (int j = 1; j <= np + 2; j++) begin
                    checks++;
                    if (o_wrdy[j] !== (j <= np) || o_done[j] !== (j == np + 1) || o_rdy[j] !== (j > np)) begin
                        fails++;
                        $display("FAIL rand_write it%0d inst%0d c%0d: wr_ready=%b wr_done=%b req_ready=%b, want %b %b %b",
                                 it, s, j, o_wrdy[j], o_done[j], o_rdy[j], j <= np, j == np + 1, j > np);
                    end
                end
            end else begin
                run_read(s, a);
                for (int j = 1; j <= rl(s) + bl(s) + 1; j++) begin
                    k = j - rl(s);
                    v = (k >= 0 && k < bl(s));
                    ed = v ? exp_beat(s, a, k) : '0;
                    checks++;
                    if (o_vld[j] !== v || o_last[j] !== (k == bl(s) - 1) || o_rdy[j] !== (j >= rl(s) + bl(s)) || o_data[j] !== ed) begin
                        fails++;
                        $display("FAIL rand_read it%0d inst%0d c%0d: vld=%b last=%b rdy=%b data=%h, want %b %b %b %h",
                                 it, s, j, o_vld[j], o_last[j], o_rdy[j], o_data[j], v, k == bl(s) - 1, j >= rl(s) + bl(s), ed);
                    end
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            wr_valid[s] = 1'b0; wr_data[s] = '0; wr_strb[s] = '0;
        end
        for (int j = 0; j < 24; j++) wpat[j] = 1'b0;
        #2 rst = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 'h800; i++) poke(s, i, 8'($urandom));
        @(posedge clk);
        #1;
        test_reset();
        test_wrapped_read();
        test_strobed_write();
        test_write_gaps();
        test_reset_mid_read();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
